// File: rtl/rgb_frame_stat.sv
// rgb_frame_stat: per-frame RGB sums, maxima, pixel and line counts latched at frame end.
// Video passes through with a fixed one-cycle delay.
module rgb_frame_stat #(
   parameter int PIXEL_WIDTH = 8,
   parameter int CNT_WIDTH   = 24,
   parameter int LINE_WIDTH  = 12,
   localparam int SUM_W      = PIXEL_WIDTH + CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   input  logic [3*PIXEL_WIDTH-1:0] di_i,
   input  logic                     de_i,
   input  logic                     hs_i,
   input  logic                     vs_i,
   output logic [3*PIXEL_WIDTH-1:0] do_o,
   output logic                     de_o,
   output logic                     hs_o,
   output logic                     vs_o,
   output logic [SUM_W-1:0]         sum_r_o,
   output logic [SUM_W-1:0]         sum_g_o,
   output logic [SUM_W-1:0]         sum_b_o,
   output logic [PIXEL_WIDTH-1:0]   max_r_o,
   output logic [PIXEL_WIDTH-1:0]   max_g_o,
   output logic [PIXEL_WIDTH-1:0]   max_b_o,
   output logic [CNT_WIDTH-1:0]     pix_cnt_o,
   output logic [LINE_WIDTH-1:0]    line_cnt_o,
   output logic                     ovf_o,
   output logic                     stat_vld_o
);
   typedef enum logic [1:0] {IDLE, WAIT_VS, ACCUM, LATCH} state_t;
   state_t state, state_n;
   logic vs_d, hs_d, vs_rise, vs_fall, hs_fall;
   logic load, accum, pix_inc, line_evt, line_inc, line_seen, ovf;
   logic [PIXEL_WIDTH-1:0] ch [3];
   logic [SUM_W-1:0] acc_sum [3];
   logic [PIXEL_WIDTH-1:0] acc_max [3];
   logic [SUM_W-1:0] stat_sum [3];
   logic [PIXEL_WIDTH-1:0] stat_max [3];
   logic [CNT_WIDTH-1:0] pix_cnt, pix_nxt;
   logic [LINE_WIDTH-1:0] line_cnt, line_nxt;

   assign vs_rise  = vs_i & ~vs_d;
   assign vs_fall  = ~vs_i & vs_d;
   assign hs_fall  = ~hs_i & hs_d;
   assign load     = (state == WAIT_VS) & vs_fall;
   assign accum    = (state == ACCUM);
   assign pix_nxt  = pix_cnt + 1'b1;
   assign line_nxt = line_cnt + 1'b1;
   assign pix_inc  = de_i & ~&pix_cnt;
   // an open line is closed either by its hs fall or by the frame-ending vs rise
   assign line_evt = (hs_fall | vs_rise) & (line_seen | de_i);
   assign line_inc = line_evt & ~&line_cnt;

   always_comb begin
      for (int c = 0; c < 3; c++) ch[c] = di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH];
   end

   always_comb begin
      state_n = (state == IDLE)    ? (en_i ? WAIT_VS : IDLE) :
                (state == WAIT_VS) ? (vs_fall ? ACCUM : WAIT_VS) :
                (state == ACCUM)   ? (vs_rise ? LATCH : ACCUM) :
                                     (en_i ? WAIT_VS : IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {do_o, de_o, hs_o, vs_o, vs_d, hs_d} <= '0;
      end else begin
         {do_o, de_o, hs_o, vs_o} <= {di_i, de_i, hs_i, vs_i};
         vs_d <= vs_i;
         hs_d <= hs_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            acc_sum[c] <= '0;
            acc_max[c] <= '0;
         end
         pix_cnt   <= '0;
         line_cnt  <= '0;
         line_seen <= 1'b0;
         ovf       <= 1'b0;
      end else if (load) begin
         for (int c = 0; c < 3; c++) begin
            acc_sum[c] <= de_i ? SUM_W'(ch[c]) : '0;
            acc_max[c] <= de_i ? ch[c] : '0;
         end
         pix_cnt   <= CNT_WIDTH'(de_i);
         line_cnt  <= '0;
         line_seen <= de_i;
         ovf       <= 1'b0;
      end else if (accum) begin
         if (pix_inc) begin
            for (int c = 0; c < 3; c++) begin
               acc_sum[c] <= acc_sum[c] + SUM_W'(ch[c]);
               acc_max[c] <= (ch[c] > acc_max[c]) ? ch[c] : acc_max[c];
            end
            pix_cnt <= pix_nxt;
         end
         if (line_inc) line_cnt <= line_nxt;
         line_seen <= ~line_evt & (line_seen | de_i);
         ovf       <= ovf | (pix_inc & &pix_nxt) | (line_inc & &line_nxt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            stat_sum[c] <= '0;
            stat_max[c] <= '0;
         end
         pix_cnt_o  <= '0;
         line_cnt_o <= '0;
         ovf_o      <= 1'b0;
         stat_vld_o <= 1'b0;
      end else begin
         stat_vld_o <= (state == LATCH);
         if (state == LATCH) begin
            for (int c = 0; c < 3; c++) begin
               stat_sum[c] <= acc_sum[c];
               stat_max[c] <= acc_max[c];
            end
            pix_cnt_o  <= pix_cnt;
            line_cnt_o <= line_cnt;
            ovf_o      <= ovf;
         end
      end
   end

   assign sum_r_o = stat_sum[0];
   assign sum_g_o = stat_sum[1];
   assign sum_b_o = stat_sum[2];
   assign max_r_o = stat_max[0];
   assign max_g_o = stat_max[1];
   assign max_b_o = stat_max[2];
endmodule

// File: tb/tb_rgb_frame_stat.sv
// tb_rgb_frame_stat: directed frames with a scoreboard per DUT instance.
// A second instance with CNT_WIDTH=3 shares the video and exercises pixel saturation.
module tb_rgb_frame_stat;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, en_s = 1'b0;
   logic [23:0] di = '0;
   logic de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [23:0] do_o, s_do;
   logic de_o, hs_o, vs_o, s_de, s_hs, s_vs;
   logic [31:0] sum_r, sum_g, sum_b;
   logic [10:0] s_sum_r, s_sum_g, s_sum_b;
   logic [7:0] max_r, max_g, max_b, s_max_r, s_max_g, s_max_b;
   logic [23:0] pix;
   logic [2:0] s_pix;
   logic [11:0] lines_o, s_lines;
   logic ovf, vld, s_ovf, s_vld;

   typedef struct {int sr, sg, sb, mr, mg, mb, pc, lc, ov;} st_t;
   st_t qm[$], qs[$];
   int checks = 0, errors = 0;
   logic [26:0] p_vid;
   logic p_ok = 1'b0;

   rgb_frame_stat dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
      .sum_r_o(sum_r), .sum_g_o(sum_g), .sum_b_o(sum_b),
      .max_r_o(max_r), .max_g_o(max_g), .max_b_o(max_b),
      .pix_cnt_o(pix), .line_cnt_o(lines_o), .ovf_o(ovf), .stat_vld_o(vld));

   rgb_frame_stat #(.CNT_WIDTH(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .en_i(en_s), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
      .do_o(s_do), .de_o(s_de), .hs_o(s_hs), .vs_o(s_vs),
      .sum_r_o(s_sum_r), .sum_g_o(s_sum_g), .sum_b_o(s_sum_b),
      .max_r_o(s_max_r), .max_g_o(s_max_g), .max_b_o(s_max_b),
      .pix_cnt_o(s_pix), .line_cnt_o(s_lines), .ovf_o(s_ovf), .stat_vld_o(s_vld));

   always #5 clk = ~clk;

   task automatic cmp(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, a, e);
      end
   endtask

   task automatic cmp_st(input string t, input st_t a, input st_t e);
      cmp({t, ".sum_r"}, a.sr, e.sr); cmp({t, ".sum_g"}, a.sg, e.sg); cmp({t, ".sum_b"}, a.sb, e.sb);
      cmp({t, ".max_r"}, a.mr, e.mr); cmp({t, ".max_g"}, a.mg, e.mg); cmp({t, ".max_b"}, a.mb, e.mb);
      cmp({t, ".pix"}, a.pc, e.pc); cmp({t, ".lines"}, a.lc, e.lc); cmp({t, ".ovf"}, a.ov, e.ov);
   endtask

   function automatic st_t get_m();
      return '{int'(sum_r), int'(sum_g), int'(sum_b), int'(max_r), int'(max_g), int'(max_b),
               int'(pix), int'(lines_o), int'(ovf)};
   endfunction

   function automatic st_t get_s();
      return '{int'(s_sum_r), int'(s_sum_g), int'(s_sum_b), int'(s_max_r), int'(s_max_g), int'(s_max_b),
               int'(s_pix), int'(s_lines), int'(s_ovf)};
   endfunction

   // scoreboard monitors: every stat pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (rst_n && vld) begin
         if (qm.size() == 0) begin
            checks++; errors++;
            $display("FAIL main unexpected stat_vld_o");
         end else cmp_st("main", get_m(), qm.pop_front());
      end
      if (rst_n && s_vld) begin
         if (qs.size() == 0) begin
            checks++; errors++;
            $display("FAIL small unexpected stat_vld_o");
         end else cmp_st("small", get_s(), qs.pop_front());
      end
   end

   always @(posedge clk) begin
      p_vid = {di, de, hs, vs};
      p_ok  = rst_n;
   end

   always @(negedge clk) if (p_ok && rst_n) cmp("passthrough", int'({do_o, de_o, hs_o, vs_o}), int'(p_vid));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit h, input bit d, input int r, input int g, input int b);
      vs = v; hs = h; de = d;
      di = {b[7:0], g[7:0], r[7:0]};
      tick();
   endtask

   task automatic vsync(input bit de_rise, input bit de_fall);
      drive(1, 0, de_rise, 7, 7, 7);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, de_fall, 7, 7, 7);
   endtask

   task automatic lines(input int nl, input int np, input int r0, input int rs, input int g, input int b);
      int k = 0;
      for (int l = 0; l < nl; l++) begin
         drive(0, 1, 0, 0, 0, 0);
         drive(0, 0, 0, 0, 0, 0);
         for (int p = 0; p < np; p++) begin
            drive(0, 0, 1, r0 + rs * k, g, b);
            k++;
         end
         drive(0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic chk_zero(input string t);
      cmp({t, ".video"}, int'({do_o, de_o, hs_o, vs_o}), 0);
      cmp_st(t, get_m(), '{0, 0, 0, 0, 0, 0, 0, 0, 0});
      cmp({t, ".vld"}, int'(vld), 0);
   endtask

   initial begin
      tick();
      chk_zero("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk_zero("post_reset");
      en = 1'b1;
      tick();
      // 3 lines x 4 pixels of 10/20/30
      vsync(0, 0);
      lines(3, 4, 10, 0, 20, 30);
      qm.push_back('{120, 240, 360, 10, 20, 30, 12, 3, 0});
      // R ramp 0..11, then constant R=5 with previous stats held mid-frame
      vsync(0, 0);
      lines(2, 6, 0, 1, 1, 2);
      qm.push_back('{66, 12, 24, 11, 1, 2, 12, 2, 0});
      vsync(0, 0);
      lines(1, 4, 5, 0, 0, 0);
      cmp("held.sum_r", int'(sum_r), 66);
      cmp("held.max_r", int'(max_r), 11);
      lines(2, 4, 5, 0, 0, 0);
      qm.push_back('{60, 0, 0, 5, 0, 0, 12, 3, 0});
      // enable dropped mid-frame: reported once, then idle
      vsync(0, 0);
      lines(1, 4, 2, 0, 2, 2);
      en = 1'b0;
      lines(1, 4, 2, 0, 2, 2);
      qm.push_back('{16, 16, 16, 2, 2, 2, 8, 2, 0});
      vsync(0, 0);
      lines(2, 4, 1, 0, 1, 1);
      vsync(0, 0);
      // re-enable mid-frame: this frame is skipped
      lines(1, 4, 3, 0, 3, 3);
      en = 1'b1;
      lines(1, 4, 3, 0, 3, 3);
      vsync(0, 0);
      lines(1, 3, 9, 0, 8, 7);
      qm.push_back('{27, 24, 21, 9, 8, 7, 3, 1, 0});
      // pixels of value 7 in both the vs_fall and the vs_rise cycle
      vsync(0, 1);
      lines(1, 4, 7, 0, 7, 7);
      qm.push_back('{42, 42, 42, 7, 7, 7, 6, 2, 0});
      en_s = 1'b1;
      vsync(1, 0);
      // 10 pixels of 1: small instance saturates at 7
      lines(2, 5, 1, 0, 1, 1);
      qm.push_back('{10, 10, 10, 1, 1, 1, 10, 2, 0});
      qs.push_back('{7, 7, 7, 1, 1, 1, 7, 2, 1});
      vsync(0, 0);
      lines(1, 4, 1, 0, 1, 1);
      en_s = 1'b0;
      qm.push_back('{4, 4, 4, 1, 1, 1, 4, 1, 0});
      qs.push_back('{4, 4, 4, 1, 1, 1, 4, 1, 0});
      vsync(0, 0);
      // reset pulse in the middle of an accumulating frame
      lines(1, 2, 3, 0, 3, 3);
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lines(1, 2, 3, 0, 3, 3);
      vsync(0, 0);
      lines(2, 3, 4, 0, 5, 6);
      qm.push_back('{24, 30, 36, 4, 5, 6, 6, 2, 0});
      vsync(0, 0);
      for (int i = 0; i < 40 && (qm.size() != 0 || qs.size() != 0); i++) tick();
      cmp("main.pending", qm.size(), 0);
      cmp("small.pending", qs.size(), 0);
      for (int i = 0; i < 10; i++) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
